// File: rtl/regfile_pkg.sv
// Shared constants and state encoding for the register-file write stage.
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_REGS       = 8;
  localparam int ADDR_WIDTH     = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/write_operation_3_to_8_decoder.sv
// One-hot write-strobe decoder shared by the handshake and clear-sweep paths.
module write_operation_3_to_8_decoder
  import regfile_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] sel_i,
  input  logic                  en_i,
  output logic [NUM_REGS-1:0]   strobe_o
);

  always_comb begin
    strobe_o = '0;
    if (en_i) strobe_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/write_operation.sv
// Write side of the 8 x DATA_WIDTH register file: valid/ready writes plus an 8-cycle clear sweep.
// Optional byte-lane write masking is enabled with `define REGFILE_BYTE_MASK_EN.
module write_operation
  import regfile_pkg::*;
#(
  parameter int                    DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   Addr,
  input  logic [DATA_WIDTH-1:0]   Data,
`ifdef REGFILE_BYTE_MASK_EN
  input  logic [DATA_WIDTH/8-1:0] wr_mask,
`endif
  input  logic                    clear_req,
  output logic                    clear_busy,
  output logic [DATA_WIDTH-1:0]   to_reg0,
  output logic [DATA_WIDTH-1:0]   to_reg1,
  output logic [DATA_WIDTH-1:0]   to_reg2,
  output logic [DATA_WIDTH-1:0]   to_reg3,
  output logic [DATA_WIDTH-1:0]   to_reg4,
  output logic [DATA_WIDTH-1:0]   to_reg5,
  output logic [DATA_WIDTH-1:0]   to_reg6,
  output logic [DATA_WIDTH-1:0]   to_reg7
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic [ADDR_WIDTH-1:0]   dec_sel;
  logic                    dec_en;
  logic [NUM_REGS-1:0]     strobe;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH-1:0]   bit_mask;

  // The sweep index and the write address share the decoder; state picks the select.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_ready   = 1'b0;
    clear_busy = 1'b0;
    dec_sel    = Addr;
    dec_en     = 1'b0;
    wdata      = Data;
    case (state_q)
      IDLE: begin
        wr_ready = !clear_req;
        dec_en   = wr_valid && !clear_req;
        if (clear_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        clear_busy = 1'b1;
        dec_sel    = idx_q;
        dec_en     = 1'b1;
        wdata      = CLEAR_VALUE;
        idx_d      = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  write_operation_3_to_8_decoder u_dec (
    .sel_i    (dec_sel),
    .en_i     (dec_en),
    .strobe_o (strobe)
  );

`ifdef REGFILE_BYTE_MASK_EN
  // Sweep writes ignore the mask and always replace the full word.
  always_comb begin
    bit_mask = '1;
    if (state_q == IDLE)
      for (int b = 0; b < DATA_WIDTH/8; b++)
        bit_mask[b*8 +: 8] = {8{wr_mask[b]}};
  end
`else
  always_comb bit_mask = '1;
`endif

  always_comb begin
    regs_d = regs_q;
    for (int r = 0; r < NUM_REGS; r++)
      if (strobe[r]) regs_d[r] = (regs_q[r] & ~bit_mask) | (wdata & bit_mask);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
    end
  end

  assign to_reg0 = regs_q[0];
  assign to_reg1 = regs_q[1];
  assign to_reg2 = regs_q[2];
  assign to_reg3 = regs_q[3];
  assign to_reg4 = regs_q[4];
  assign to_reg5 = regs_q[5];
  assign to_reg6 = regs_q[6];
  assign to_reg7 = regs_q[7];

endmodule

// File: tb/tb_write_operation.sv
// Self-checking bench for write_operation: vector table, write scoreboard, clear-sweep sequences.
module tb_write_operation;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  Addr = '0;
  logic [31:0] Data = '0;
`ifdef REGFILE_BYTE_MASK_EN
  logic [3:0]  wr_mask = 4'hF;
`endif
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic [31:0] to_reg0, to_reg1, to_reg2, to_reg3, to_reg4, to_reg5, to_reg6, to_reg7;
  wire  [31:0] to_reg [8];

  assign to_reg[0] = to_reg0;
  assign to_reg[1] = to_reg1;
  assign to_reg[2] = to_reg2;
  assign to_reg[3] = to_reg3;
  assign to_reg[4] = to_reg4;
  assign to_reg[5] = to_reg5;
  assign to_reg[6] = to_reg6;
  assign to_reg[7] = to_reg7;

  always #5 clk = ~clk;

  write_operation dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .Addr       (Addr),
    .Data       (Data),
`ifdef REGFILE_BYTE_MASK_EN
    .wr_mask    (wr_mask),
`endif
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .to_reg0    (to_reg0),
    .to_reg1    (to_reg1),
    .to_reg2    (to_reg2),
    .to_reg3    (to_reg3),
    .to_reg4    (to_reg4),
    .to_reg5    (to_reg5),
    .to_reg6    (to_reg6),
    .to_reg7    (to_reg7)
  );

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0]  addr;
    logic [31:0] data;
  } sb_t;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] model [8];
  sb_t         sbq [$];
  vec_t        vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_all(input string name);
    for (int i = 0; i < 8; i++) check($sformatf("%s_r%0d", name, i), to_reg[i], model[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one write expected to be accepted at the next edge; score it after that edge.
  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input string name);
    sb_t e;
    wr_valid = 1'b1;
    Addr     = a;
    Data     = d;
    #1;
    check({name, "_ready"}, {31'b0, wr_ready}, 32'd1);
    sbq.push_back('{a, d});
    model[a] = d;
    tick();
    wr_valid = 1'b0;
    if (sbq.size() == 0) begin
      check({name, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check(name, to_reg[e.addr], e.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;
    vecs[0] = '{3'd5, 32'h1234_5678, 32'h1234_5678};
    for (int n = 0; n < 8; n++) vecs[n+1] = '{3'(n), 32'hA0 + 32'(n), 32'hA0 + 32'(n)};

    // Reset held for two cycles with a competing write request.
    reset = 1'b1; wr_valid = 1'b1; Addr = 3'd3; Data = 32'hDEAD_BEEF;
    tick(); tick();
    reset = 1'b0; wr_valid = 1'b0;
    #1;
    check_all("reset");
    check("reset_ready", {31'b0, wr_ready}, 32'd1);
    check("reset_busy", {31'b0, clear_busy}, 32'd0);

    // Single write, then back-to-back writes to all registers.
    for (int v = 0; v < 9; v++) begin
      do_write(vecs[v].addr, vecs[v].data, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_exp", v), to_reg[vecs[v].addr], vecs[v].exp);
      if (v == 0) check_all("single");
    end
    check_all("b2b");

    // Preload all ones, then collide clear_req with a write to reg 2.
    for (int n = 0; n < 8; n++) do_write(3'(n), 32'hFFFF_FFFF, $sformatf("pre%0d", n));
    clear_req = 1'b1; wr_valid = 1'b1; Addr = 3'd2; Data = 32'h55;
    #1;
    check("coll_ready", {31'b0, wr_ready}, 32'd0);
    tick();
    clear_req = 1'b0;
    check("coll_not_written", to_reg2, 32'hFFFF_FFFF);
    for (int k = 0; k < 8; k++) begin
      clear_req = (k == 3);
      #1;
      check($sformatf("sweep%0d_busy", k), {31'b0, clear_busy}, 32'd1);
      check($sformatf("sweep%0d_ready", k), {31'b0, wr_ready}, 32'd0);
      tick();
      model[k] = '0;
      check_all($sformatf("sweep%0d", k));
    end
    clear_req = 1'b0;
    #1;
    check("post_sweep_busy", {31'b0, clear_busy}, 32'd0);
    check("post_sweep_ready", {31'b0, wr_ready}, 32'd1);
    do_write(3'd2, 32'h55, "held_write");
    check_all("held");

    // Reset arriving in the fourth sweep cycle aborts the sweep.
    do_write(3'd6, 32'h66, "pre6");
    do_write(3'd7, 32'h77, "pre7");
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    tick(); tick(); tick();
    #1;
    check("mid_busy_before_reset", {31'b0, clear_busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model[i] = '0;
    check("abort_busy", {31'b0, clear_busy}, 32'd0);
    check("abort_ready", {31'b0, wr_ready}, 32'd1);
    check_all("abort");
    tick(); tick();
    check("abort_busy_later", {31'b0, clear_busy}, 32'd0);
    do_write(3'd4, 32'hCAFE_F00D, "after_abort");
    check_all("after_abort");

`ifdef REGFILE_BYTE_MASK_EN
    wr_mask = 4'hF;
    do_write(3'd1, 32'h1111_1111, "mask_pre");
    wr_mask = 4'b0101;
    wr_valid = 1'b1; Addr = 3'd1; Data = 32'hAABB_CCDD;
    tick();
    wr_valid = 1'b0;
    check("mask_0101", to_reg1, 32'h11BB_11DD);
    wr_mask = 4'b0000;
    wr_valid = 1'b1; Addr = 3'd1; Data = 32'h0000_0000;
    tick();
    wr_valid = 1'b0;
    check("mask_zero", to_reg1, 32'h11BB_11DD);
    wr_mask = 4'hF;
`endif

    check("sb_drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
